// File: rtl/huff_bit_unpacker_if.sv
// Stream-side and decoder-side signals of the Huffman bit unpacker.
// The source/decoder end is the master, and the unpacker is the slave.
interface huff_bit_unpacker_if #(
    parameter int WORD_W = 32,
    parameter int WIN_W  = 16
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [WIN_W-1:0]  win;
    logic              win_valid;
    logic              cons_en;
    logic [4:0]        cons_len;
    logic [6:0]        bit_cnt;
    logic              eos;
    logic              err;
    logic              clear;

    modport master (
        output in_data, in_valid, in_last, cons_en, cons_len, clear,
        input  in_ready, win, win_valid, bit_cnt, eos, err
    );

    modport slave (
        input  in_data, in_valid, in_last, cons_en, cons_len, clear,
        output in_ready, win, win_valid, bit_cnt, eos, err
    );
endinterface

// File: rtl/huff_bit_unpacker.sv
// Receive-side bit unpacker: takes MSB-first 32-bit words and exposes a 16-bit look-ahead window.
// Each cycle the decoder retires 1..16 bits from that window.
module huff_bit_unpacker #(
    parameter int WORD_W = 32,
    parameter int WIN_W  = 16,
    parameter int BUF_W  = 64
) (
    input  logic                clk,
    input  logic                rst,
    huff_bit_unpacker_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [6:0] WIN_LEN   = 7'(WIN_W);
    localparam logic [6:0] WORD_LEN  = 7'(WORD_W);
    localparam logic [6:0] READY_MAX = 7'(BUF_W - WORD_W);

    state_t           r_state;
    logic [BUF_W-1:0] r_buf;
    logic [6:0]       r_bit_cnt;
    logic             r_err;

    logic             w_in_ready;
    logic             w_win_valid;
    logic             w_accept;
    logic [6:0]       w_len;
    logic             w_cons_ok;
    logic             w_cons_bad;
    logic [BUF_W-1:0] w_buf_shift;
    logic [BUF_W-1:0] w_word_pos;
    logic [BUF_W-1:0] w_buf_next;
    logic [6:0]       w_cnt_shift;
    logic [6:0]       w_cnt_next;

    // Ready and window-valid come from registers only, so there is no path from cons_en to in_ready.
    assign w_in_ready  = (r_state == S_STREAM) && (r_bit_cnt <= READY_MAX);
    assign w_win_valid = (r_bit_cnt >= WIN_LEN) || ((r_state == S_DRAIN) && (r_bit_cnt != 7'd0));
    assign w_accept    = bus.in_valid && w_in_ready;

    assign w_len      = {2'b00, bus.cons_len};
    assign w_cons_ok  = bus.cons_en && w_win_valid && (w_len != 7'd0) &&
                        (w_len <= WIN_LEN) && (w_len <= r_bit_cnt);
    assign w_cons_bad = bus.cons_en && !w_cons_ok;

    // Shift out the consumed bits first, then place the new word just below what is left.
    always_comb begin
        // NOTE: every signal gets a default before the conditional updates so no latch is inferred.
        w_buf_shift = r_buf;
        w_cnt_shift = r_bit_cnt;
        if (w_cons_ok) begin
            w_buf_shift = r_buf << w_len;
            w_cnt_shift = r_bit_cnt - w_len;
        end
        w_word_pos = {bus.in_data, {(BUF_W-WORD_W){1'b0}}} >> w_cnt_shift;
        w_buf_next = w_buf_shift;
        w_cnt_next = w_cnt_shift;
        if (w_accept) begin
            w_buf_next = w_buf_shift | w_word_pos;
            w_cnt_next = w_cnt_shift + WORD_LEN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the buffer is reset and cleared because win reads it directly, and bits beyond bit_cnt must read 0.
            r_state   <= S_IDLE;
            r_buf     <= '0;
            r_bit_cnt <= '0;
            r_err     <= 1'b0;
        end else if (bus.clear) begin
            r_state   <= S_STREAM;
            r_buf     <= '0;
            r_bit_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_buf     <= w_buf_next;
            r_bit_cnt <= w_cnt_next;
            if (w_cons_bad) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE:   r_state <= S_STREAM;
                S_STREAM: if (w_accept && bus.in_last) r_state <= S_DRAIN;
                S_DRAIN:  if (w_cnt_next == 7'd0) r_state <= S_DONE;
                default:  r_state <= r_state;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.win       = r_buf[BUF_W-1 -: WIN_W];
    assign bus.win_valid = w_win_valid;
    assign bus.bit_cnt   = r_bit_cnt;
    assign bus.eos       = (r_state == S_DONE);
    assign bus.err       = r_err;
endmodule

// File: tb/tb_huff_bit_unpacker.sv
// Scoreboard bench for huff_bit_unpacker. A bit-queue model of the stream produces the expected outputs.
// Each expected result is queued when the stimulus is driven, then checked one cycle later.
module tb_huff_bit_unpacker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    huff_bit_unpacker_if bus ();

    huff_bit_unpacker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {M_IDLE, M_STREAM, M_DRAIN, M_DONE} mstate_t;

    typedef struct {
        logic [15:0] win;
        logic        win_valid;
        logic [6:0]  bit_cnt;
        logic        in_ready;
        logic        eos;
        logic        err;
    } exp_t;

    exp_t    sb_q[$];
    bit      m_bits[$];
    mstate_t m_state;
    bit      m_err;
    bit      m_acc;
    int      n_checks = 0;
    int      n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_state = M_IDLE;
        m_err   = 1'b0;
        m_acc   = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit last,
                              input bit ce, input int len, input bit clr);
        int sz;
        bit wv;
        bit rdy;
        bit ok;
        sz  = m_bits.size();
        wv  = (sz >= 16) || (m_state == M_DRAIN && sz > 0);
        rdy = (m_state == M_STREAM) && (sz <= 32);
        m_acc = 1'b0;
        if (clr) begin
            m_bits.delete();
            m_state = M_STREAM;
            m_err   = 1'b0;
            return;
        end
        ok = ce && wv && (len >= 1) && (len <= 16) && (len <= sz);
        if (ce && !ok) m_err = 1'b1;
        if (ok) repeat (len) void'(m_bits.pop_front());
        if (v && rdy) begin
            m_acc = 1'b1;
            for (int i = 31; i >= 0; i--) m_bits.push_back(d[i]);
        end
        case (m_state)
            M_IDLE:   m_state = M_STREAM;
            M_STREAM: if (m_acc && last) m_state = M_DRAIN;
            M_DRAIN:  if (m_bits.size() == 0) m_state = M_DONE;
            default:  ;
        endcase
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        int   sz;
        sz = m_bits.size();
        e.win = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < sz) e.win[15-i] = m_bits[i];
        end
        e.bit_cnt   = 7'(sz);
        e.win_valid = (sz >= 16) || (m_state == M_DRAIN && sz > 0);
        e.in_ready  = (m_state == M_STREAM) && (sz <= 32);
        e.eos       = (m_state == M_DONE);
        e.err       = m_err;
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check("win",       bus.win,       e.win);
        check("win_valid", bus.win_valid, e.win_valid);
        check("bit_cnt",   bus.bit_cnt,   e.bit_cnt);
        check("in_ready",  bus.in_ready,  e.in_ready);
        check("eos",       bus.eos,       e.eos);
        check("err",       bus.err,       e.err);
        check("bit_cnt_le_64", bus.bit_cnt <= 7'd64, 64'd1);
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit last,
                        input bit ce, input int len, input bit clr);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.cons_en  = ce;
        bus.cons_len = 5'(len);
        bus.clear    = clr;
        model_step(v, d, last, ce, len, clr);
        sb_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_win"},       bus.win,       64'd0);
        check({tag, "_win_valid"}, bus.win_valid, 64'd0);
        check({tag, "_bit_cnt"},   bus.bit_cnt,   64'd0);
        check({tag, "_in_ready"},  bus.in_ready,  64'd0);
        check({tag, "_eos"},       bus.eos,       64'd0);
        check({tag, "_err"},       bus.err,       64'd0);
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.cons_en  = 1'b0;
        bus.cons_len = '0;
        bus.clear    = 1'b0;
    endtask

    initial begin
        logic [31:0] word;
        bit          word_last;
        int          len;

        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed sequence: load, partial consumes, concurrent accept+consume, backpressure.
        step(0, 32'h0, 0, 0, 0, 0);
        step(1, 32'hA5A50F0F, 0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 4, 0);
        step(0, 32'h0, 0, 1, 12, 0);
        step(1, 32'hFFFF0000, 0, 1, 16, 0);
        step(1, 32'h12345678, 0, 0, 0, 0);
        repeat (3) step(1, 32'h9ABCDEF0, 0, 0, 0, 0);
        repeat (3) step(1, 32'h9ABCDEF0, 0, 1, 16, 0);
        while (m_bits.size() >= 16) step(0, 32'h0, 0, 1, 16, 0);

        // Final word and drain below the window width.
        step(1, 32'h80000000, 1, 0, 0, 0);
        step(0, 32'h0, 0, 1, 1, 0);
        step(0, 32'h0, 0, 1, 16, 0);
        step(0, 32'h0, 0, 1, 15, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        step(1, 32'h11111111, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 1);

        // Over-consume in DRAIN, then a legal finish and clear.
        step(1, 32'hCAFEBABE, 1, 0, 0, 0);
        step(0, 32'h0, 0, 1, 16, 0);
        step(0, 32'h0, 0, 1, 12, 0);
        step(0, 32'h0, 0, 1, 8, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 4, 0);
        step(0, 32'h0, 0, 0, 0, 1);

        // Illegal lengths in STREAM, and clear winning over accept and consume.
        step(1, 32'h0F0F0F0F, 0, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0, 1);
        step(1, 32'h13579BDF, 0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 17, 0);
        step(1, 32'hDEADBEEF, 0, 1, 4, 1);
        step(0, 32'h0, 0, 0, 0, 0);

        // Random traffic; each word and its last flag stay put until accepted.
        word      = $urandom;
        word_last = ($urandom_range(0, 29) == 0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 20);
            else len = $urandom_range(1, 16);
            step($urandom_range(0, 1) == 1, word, word_last,
                 $urandom_range(0, 3) != 0, len, $urandom_range(0, 59) == 0);
            if (m_acc) begin
                word      = $urandom;
                word_last = ($urandom_range(0, 29) == 0);
            end
        end

        // Asynchronous reset in the middle of a stream.
        step(0, 32'h0, 0, 0, 0, 1);
        step(1, 32'h5A5AC3C3, 0, 0, 0, 0);
        step(1, 32'h0123ABCD, 0, 1, 7, 0);
        #3;
        rst = 1'b1;
        idle_inputs();
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        step(0, 32'h0, 0, 0, 0, 0);
        step(1, 32'h3C3C9696, 0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 5, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
